// File: rtl/m_epp_host.sv
// m_epp_host -- EPP host (initiator) behind a Wishbone slave port.
//
// A Wishbone access to address 0 or 1 runs one EPP address or data cycle
// towards an external peripheral. The sequence is:
//   1. Drive nWRITE and DB for SETUPCYC cycles.
//   2. Drop the matching strobe.
//   3. Wait for WAIT to rise, then release the strobe.
//   4. Wait for WAIT to fall, then ACK the Wishbone master.
// A missing WAIT edge aborts the cycle after TOCYC cycles. The abort sets a
// sticky timeout flag, and a read then returns 8'hFF.
// Address 2 is status {6'b0, wait_s, tmo}; writing bit0=1 clears tmo.
// Address 3 is reserved: it reads 0 and ignores writes.
// Pad tristates live in the top level; DB is exposed as separate o/oe/i.
//
// Ports:
//   CLK_I, RST_I        clock, synchronous active-high reset
//   STB_I, WE_I, ADR_I  Wishbone strobe, write enable, 2-bit address
//   DAT_I, DAT_O        Wishbone write / read data (8 bit)
//   ACK_O               single-cycle acknowledge
//   epp_nADDRSTB        address strobe, active low
//   epp_nDATASTB        data strobe, active low
//   epp_nWRITE          0 = host writes, 1 = host reads
//   epp_DB_o/oe/i       bus data out / output enable / in
//   epp_WAIT            peripheral handshake (asynchronous)
module m_epp_host #(
  parameter int unsigned SETUPCYC = 2,
  parameter int unsigned TOCYC    = 1023
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       STB_I,
  input  logic       WE_I,
  input  logic [1:0] ADR_I,
  input  logic [7:0] DAT_I,
  output logic [7:0] DAT_O,
  output logic       ACK_O,
  output logic       epp_nADDRSTB,
  output logic       epp_nDATASTB,
  output logic       epp_nWRITE,
  output logic [7:0] epp_DB_o,
  output logic       epp_DB_oe,
  input  logic [7:0] epp_DB_i,
  input  logic       epp_WAIT
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE, S_REG
  } state_t;

  localparam logic [15:0] SETUP_LAST = 16'(SETUPCYC - 1);
  localparam logic [15:0] TO_LAST    = 16'(TOCYC - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        we_q, we_nxt;
  logic        adr0_q, adr0_nxt;
  logic [7:0]  rdata, rdata_nxt;
  logic        tmo, tmo_nxt;
  logic        skip, skip_nxt;
  logic        nadr_nxt, ndat_nxt, nwr_nxt, oe_nxt, ack_nxt;
  logic [7:0]  dbo_nxt, dat_nxt;
  logic        go_done;
  logic [7:0]  done_rd;
  logic        wait_p0, wait_s;

  // WAIT synchroniser: wait_p0 is the metastability stage, wait_s is the
  // value the FSM uses.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      wait_p0 <= 1'b0;
      wait_s  <= 1'b0;
    end else begin
      wait_p0 <= epp_WAIT;
      wait_s  <= wait_p0;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state        <= S_IDLE;
      cnt          <= 16'd0;
      we_q         <= 1'b0;
      adr0_q       <= 1'b0;
      rdata        <= 8'h00;
      tmo          <= 1'b0;
      skip         <= 1'b0;
      epp_nADDRSTB <= 1'b1;
      epp_nDATASTB <= 1'b1;
      epp_nWRITE   <= 1'b1;
      epp_DB_o     <= 8'h00;
      epp_DB_oe    <= 1'b0;
      ACK_O        <= 1'b0;
      DAT_O        <= 8'h00;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      we_q         <= we_nxt;
      adr0_q       <= adr0_nxt;
      rdata        <= rdata_nxt;
      tmo          <= tmo_nxt;
      skip         <= skip_nxt;
      epp_nADDRSTB <= nadr_nxt;
      epp_nDATASTB <= ndat_nxt;
      epp_nWRITE   <= nwr_nxt;
      epp_DB_o     <= dbo_nxt;
      epp_DB_oe    <= oe_nxt;
      ACK_O        <= ack_nxt;
      DAT_O        <= dat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we_nxt    = we_q;
    adr0_nxt  = adr0_q;
    rdata_nxt = rdata;
    tmo_nxt   = tmo;
    skip_nxt  = 1'b0;
    nadr_nxt  = epp_nADDRSTB;
    ndat_nxt  = epp_nDATASTB;
    nwr_nxt   = epp_nWRITE;
    dbo_nxt   = epp_DB_o;
    oe_nxt    = epp_DB_oe;
    ack_nxt   = 1'b0;
    dat_nxt   = DAT_O;
    go_done   = 1'b0;
    done_rd   = rdata;

    case (state)
      S_IDLE: begin
        // skip masks the cycle right after an ACK, so a strobe the master
        // still holds is not taken as a second access.
        if (STB_I && !skip) begin
          if (!ADR_I[1]) begin
            // An EPP cycle must not start while the previous handshake
            // is still visible on WAIT.
            if (!wait_s) begin
              state_nxt = S_SETUP;
              cnt_nxt   = 16'd0;
              we_nxt    = WE_I;
              adr0_nxt  = ADR_I[0];
              nwr_nxt   = ~WE_I;
              oe_nxt    = WE_I;
              dbo_nxt   = DAT_I;
            end
          end else begin
            state_nxt = S_REG;
            ack_nxt   = 1'b1;
            dat_nxt   = (!WE_I && !ADR_I[0]) ? {6'b0, wait_s, tmo} : 8'h00;
            if (WE_I && !ADR_I[0] && DAT_I[0]) begin
              tmo_nxt = 1'b0;
            end
          end
        end
      end

      S_SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nxt = S_STROBE;
          cnt_nxt   = 16'd0;
          nadr_nxt  = adr0_q;
          ndat_nxt  = ~adr0_q;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end

      S_STROBE: begin
        if (wait_s) begin
          rdata_nxt = epp_DB_i;
          nadr_nxt  = 1'b1;
          ndat_nxt  = 1'b1;
          state_nxt = S_HOLD;
          cnt_nxt   = 16'd0;
        end else if (cnt == TO_LAST) begin
          tmo_nxt   = 1'b1;
          nadr_nxt  = 1'b1;
          ndat_nxt  = 1'b1;
          rdata_nxt = 8'hFF;
          done_rd   = 8'hFF;
          go_done   = 1'b1;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end

      S_HOLD: begin
        if (!wait_s) begin
          go_done = 1'b1;
        end else if (cnt == TO_LAST) begin
          tmo_nxt   = 1'b1;
          rdata_nxt = 8'hFF;
          done_rd   = 8'hFF;
          go_done   = 1'b1;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end

      S_DONE, S_REG: begin
        state_nxt = S_IDLE;
        skip_nxt  = 1'b1;
      end

      default: state_nxt = S_IDLE;
    endcase

    // Common exit into DONE. The bus is released here. The ACK is dropped
    // when the master has already abandoned the access.
    if (go_done) begin
      state_nxt = S_DONE;
      nwr_nxt   = 1'b1;
      oe_nxt    = 1'b0;
      ack_nxt   = STB_I;
      dat_nxt   = we_q ? 8'h00 : done_rd;
    end
  end

endmodule

// File: tb/tb_m_epp_host.sv
module tb_m_epp_host;

  logic       clk = 1'b0;
  logic       RST_I, STB_I, WE_I;
  logic [1:0] ADR_I;
  logic [7:0] DAT_I, DAT_O;
  logic       ACK_O;
  logic       epp_nADDRSTB, epp_nDATASTB, epp_nWRITE, epp_DB_oe;
  logic [7:0] epp_DB_o;
  logic [7:0] epp_DB_i = 8'h00;
  logic       epp_WAIT = 1'b0;

  always #5 clk = ~clk;

  m_epp_host #(.SETUPCYC(2), .TOCYC(16)) dut (
    .CLK_I(clk), .RST_I(RST_I), .STB_I(STB_I), .WE_I(WE_I), .ADR_I(ADR_I),
    .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK_O(ACK_O),
    .epp_nADDRSTB(epp_nADDRSTB), .epp_nDATASTB(epp_nDATASTB),
    .epp_nWRITE(epp_nWRITE), .epp_DB_o(epp_DB_o), .epp_DB_oe(epp_DB_oe),
    .epp_DB_i(epp_DB_i), .epp_WAIT(epp_WAIT)
  );

  // Peripheral model, in the style of an m_digilent EPP slave. It has an
  // address register plus four data registers. It answers a strobe
  // per_dly cycles after it falls, and drops WAIT once both strobes are high.
  logic       per_en = 1'b1;
  int         per_dly = 3;
  int         dly_cnt = 0;
  logic [7:0] per_addr = 8'h3C;
  logic [7:0] mem [4];

  always @(negedge clk) begin
    if (!per_en) begin
      epp_WAIT = 1'b0;
      dly_cnt  = 0;
    end else if (!epp_WAIT) begin
      if (!epp_nADDRSTB || !epp_nDATASTB) begin
        if (dly_cnt >= per_dly - 1) begin
          if (!epp_nWRITE) begin
            if (!epp_nADDRSTB) per_addr = epp_DB_o;
            else mem[per_addr[1:0]] = epp_DB_o;
          end else begin
            epp_DB_i = !epp_nADDRSTB ? per_addr : mem[per_addr[1:0]];
          end
          epp_WAIT = 1'b1;
          dly_cnt  = 0;
        end else begin
          dly_cnt = dly_cnt + 1;
        end
      end else begin
        dly_cnt = 0;
      end
    end else if (epp_nADDRSTB && epp_nDATASTB) begin
      epp_WAIT = 1'b0;
    end
  end

  // Bus monitor. It counts protocol violations, ACK pulses, address-strobe
  // falls and DB_oe cycles. It also measures the length of the last strobe
  // pulse and the write setup that came before it.
  int         viol = 0, ack_cnt = 0, afalls = 0, oe_cyc = 0;
  int         low_run = 0, last_low = 0, wrun = 0, last_wsetup = 0;
  logic [7:0] last_db = 8'h00;
  logic       prev_low = 1'b0, prev_a = 1'b1;

  always @(negedge clk) begin
    if (!RST_I) begin
      if (!epp_nADDRSTB && !epp_nDATASTB) viol = viol + 1;
      if (epp_DB_oe && epp_nWRITE) viol = viol + 1;
      if (ACK_O) ack_cnt = ack_cnt + 1;
      if (epp_DB_oe) oe_cyc = oe_cyc + 1;
      if (prev_a && !epp_nADDRSTB) afalls = afalls + 1;
      if (!epp_nADDRSTB || !epp_nDATASTB) begin
        if (!prev_low) begin
          last_wsetup = wrun;
          last_db     = epp_DB_o;
        end
        wrun    = 0;
        low_run = low_run + 1;
        prev_low = 1'b1;
      end else begin
        if (prev_low) begin
          last_low = low_run;
          low_run  = 0;
        end
        prev_low = 1'b0;
        if (!epp_nWRITE && epp_DB_oe) wrun = wrun + 1;
        else wrun = 0;
      end
      prev_a = epp_nADDRSTB;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic [1:0] adr, input logic we, input logic [7:0] dat,
                    output logic [7:0] rd, output logic ok);
    ok = 1'b0;
    rd = 8'h00;
    ADR_I = adr; WE_I = we; DAT_I = dat; STB_I = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ACK_O === 1'b1) begin
        ok = 1'b1;
        rd = DAT_O;
        break;
      end
    end
    @(posedge clk);
    #1 STB_I = 1'b0; WE_I = 1'b0;
  endtask

  logic [7:0] rd;
  logic       ok, found;
  int         a0, f0, o0;

  initial begin
    RST_I = 1'b1; STB_I = 1'b0; WE_I = 1'b0; ADR_I = 2'd0; DAT_I = 8'h00;
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_naddrstb", epp_nADDRSTB, 1);
    chk("rst_ndatastb", epp_nDATASTB, 1);
    chk("rst_nwrite", epp_nWRITE, 1);
    chk("rst_db_oe", epp_DB_oe, 0);
    chk("rst_db_o", epp_DB_o, 8'h00);
    chk("rst_ack", ACK_O, 0);
    chk("rst_dat_o", DAT_O, 8'h00);
    RST_I = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Data write of A5: two setup cycles, then one ACK.
    a0 = ack_cnt; f0 = afalls;
    wb(2'd1, 1'b1, 8'hA5, rd, ok);
    chk("wr_ack", ok, 1);
    chk("wr_setup_len", last_wsetup, 2);
    chk("wr_setup_db", last_db, 8'hA5);
    chk("wr_wdat_o", rd, 8'h00);
    chk("wr_addrstb_quiet", afalls - f0, 0);
    chk("wr_ack_count", ack_cnt - a0, 1);
    chk("wr_mem", mem[0], 8'hA5);

    // Address read: the peripheral returns 3C and DB is never driven.
    o0 = oe_cyc;
    wb(2'd0, 1'b0, 8'h00, rd, ok);
    chk("ard_ack", ok, 1);
    chk("ard_data", rd, 8'h3C);
    chk("ard_no_oe", oe_cyc - o0, 0);

    // Timeout with WAIT stuck low.
    per_en = 1'b0;
    wb(2'd1, 1'b0, 8'h00, rd, ok);
    chk("to_ack", ok, 1);
    chk("to_data", rd, 8'hFF);
    chk("to_strobe_len", last_low, 16);
    per_en = 1'b1;
    wb(2'd2, 1'b0, 8'h00, rd, ok);
    chk("to_status", rd, 8'h01);
    wb(2'd2, 1'b1, 8'h01, rd, ok);
    chk("to_clr_ack", ok, 1);
    wb(2'd2, 1'b0, 8'h00, rd, ok);
    chk("to_status_clr", rd, 8'h00);
    wb(2'd3, 1'b0, 8'h00, rd, ok);
    chk("rsv_read", rd, 8'h00);

    // Loopback through the address and data registers.
    wb(2'd0, 1'b1, 8'h01, rd, ok);
    chk("lb_addr_ack", ok, 1);
    wb(2'd1, 1'b1, 8'h5A, rd, ok);
    chk("lb_data_ack", ok, 1);
    wb(2'd1, 1'b0, 8'h00, rd, ok);
    chk("lb_readback", rd, 8'h5A);
    wb(2'd2, 1'b0, 8'h00, rd, ok);
    chk("lb_no_tmo", rd, 8'h00);

    // Reset asserted while the strobe is low.
    per_dly = 8;
    a0 = ack_cnt;
    ADR_I = 2'd1; WE_I = 1'b1; DAT_I = 8'h77; STB_I = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!epp_nADDRSTB || !epp_nDATASTB) begin
        found = 1'b1;
        break;
      end
    end
    chk("mr_strobe_seen", found, 1);
    RST_I = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_ndatastb", epp_nDATASTB, 1);
    chk("mr_naddrstb", epp_nADDRSTB, 1);
    chk("mr_db_oe", epp_DB_oe, 0);
    chk("mr_ack", ACK_O, 0);
    RST_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("mr_no_ack", ack_cnt - a0, 0);
    per_dly = 3;
    wb(2'd1, 1'b0, 8'h00, rd, ok);
    chk("mr_next_ack", ok, 1);
    chk("mr_next_data", rd, 8'h5A);

    // STB_I dropped in HOLD: the EPP cycle completes with no ACK.
    a0 = ack_cnt;
    ADR_I = 2'd1; WE_I = 1'b1; DAT_I = 8'hC3; STB_I = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!epp_nDATASTB) begin
        found = 1'b1;
        break;
      end
    end
    for (int i = 0; i < 50; i++) begin
      if (epp_nDATASTB && epp_nADDRSTB) break;
      @(negedge clk);
    end
    chk("dh_strobe_seen", found, 1);
    STB_I = 1'b0; WE_I = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("dh_no_ack", ack_cnt - a0, 0);
    chk("dh_nwrite_idle", epp_nWRITE, 1);
    chk("dh_oe_idle", epp_DB_oe, 0);
    wb(2'd1, 1'b0, 8'h00, rd, ok);
    chk("dh_next_ack", ok, 1);
    chk("dh_next_data", rd, 8'hC3);

    chk("protocol_violations", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
